// File: rtl/imem_pkg.sv
// imem_pkg: shared constants, response record and address check for the instruction memory responder
package imem_pkg;
  localparam int RSP_FIFO_DEPTH = 4;
  localparam int PTR_W = $clog2(RSP_FIFO_DEPTH);
  localparam int CNT_W = $clog2(RSP_FIFO_DEPTH + 1);
  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 4;
  typedef struct packed {
    logic [31:0] data;
    logic [31:0] addr;
    logic        err;
  } rsp_t;
  function automatic logic addr_bad(input logic [31:0] a, input int depth);
    return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= 32'(depth));
  endfunction
endpackage

// File: rtl/resp_fifo.sv
// resp_fifo: small in-order response queue with modulo-wrapping pointers
module resp_fifo
  import imem_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  rsp_t             push_data,
  input  logic             pop,
  output rsp_t             head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  rsp_t             store [RSP_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;
  assign full    = count == CNT_W'(RSP_FIFO_DEPTH);
  assign empty   = count == '0;
  assign head    = store[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // storage needs no reset; occupancy is tracked by the pointers and count
  always_ff @(posedge clk)
    if (do_push) store[wr_ptr] <= push_data;
  // pointer and occupancy bookkeeping; simultaneous push and pop keeps count
  always_ff @(posedge clk)
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
endmodule

// File: rtl/imem_responder.sv
// imem_responder: fixed-latency instruction fetch responder with program-load port
module imem_responder
  import imem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [31:0] rsp_addr,
  output logic        rsp_err,
  input  logic        flush,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data
);
  localparam int LAT = (LATENCY < LATENCY_MIN) ? LATENCY_MIN :
                       (LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY;
  localparam int AW = $clog2(DEPTH);
  logic [31:0]      mem [DEPTH];
  logic [LAT-1:0]   st_valid;
  rsp_t             st [LAT];
  rsp_t             head;
  rsp_t             out;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] outstanding;
  logic             req_bad;
  logic             accept;
  logic             pop;
  logic             push;
  assign req_bad     = addr_bad(req_addr, DEPTH);
  assign outstanding = fifo_count + CNT_W'($countones(st_valid));
  assign req_ready   = !reset && !flush && (outstanding < CNT_W'(RSP_FIFO_DEPTH));
  assign accept      = req_valid && req_ready;
  assign rsp_valid   = !reset && !flush && (!fifo_empty || st_valid[LAT-1]);
  assign out         = fifo_empty ? st[LAT-1] : head;
  assign pop         = rsp_valid && rsp_ready;
  assign push        = st_valid[LAT-1] && !(fifo_empty && pop) && (!fifo_full || pop);
  assign rsp_data    = rsp_valid ? out.data : '0;
  assign rsp_addr    = rsp_valid ? out.addr : '0;
  assign rsp_err     = rsp_valid && out.err;
  // program-load writes; memory is deliberately untouched by reset
  always_ff @(posedge clk)
    if (wr_en && !addr_bad(wr_addr, DEPTH)) mem[wr_addr[AW+1:2]] <= wr_data;
  // delay-line valids; flush and reset drop everything in flight
  always_ff @(posedge clk)
    if (reset || flush) st_valid <= '0;
    else begin
      st_valid[0] <= accept;
      for (int i = 1; i < LAT; i++) st_valid[i] <= st_valid[i-1];
    end
  // delay-line payload: memory is read at accept, so a same-edge write returns old data
  always_ff @(posedge clk) begin
    st[0] <= '{data: req_bad ? NOP_INSTR : mem[req_addr[AW+1:2]], addr: req_addr, err: req_bad};
    for (int i = 1; i < LAT; i++) st[i] <= st[i-1];
  end
  resp_fifo u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .push      (push),
    .push_data (st[LAT-1]),
    .pop       (pop && !fifo_empty),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );
endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 The block SHALL have exactly one clock; reset is synchronous and active-high.
REQ-002 Parameters SHALL be, one per line:
- DEPTH, 256, instruction memory size in 32-bit words.
- LATENCY, 2, accept-to-response delay in cycles; legal range 1..4.
REQ-003 Ports SHALL be, one per line:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  fetch request valid.
- req_ready  output  1  request can be accepted this cycle.
- req_addr  input  32  byte address (PC) to fetch.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  consumer takes response this cycle.
- rsp_data  output  32  instruction word.
- rsp_addr  output  32  address the response belongs to.
- rsp_err  output  1  fault: misaligned or out-of-range address.
- flush  input  1  discard all outstanding and pending fetches.
- wr_en  input  1  program-load write strobe.
- wr_addr  input  32  program-load byte address.
- wr_data  input  32  program-load word.

Function
REQ-004 A request SHALL be accepted on a rising edge where req_valid=1, req_ready=1 and flush=0.
REQ-005 Each accepted request SHALL read memory in its accept cycle and travel through a LATENCY-stage valid/data/addr delay line, then enter a 4-entry response FIFO.
REQ-006 With an empty FIFO and rsp_ready=1, a response SHALL become visible on rsp_valid exactly LATENCY cycles after acceptance.
REQ-007 Responses SHALL be returned strictly in acceptance order, with rsp_addr equal to the accepted req_addr.
REQ-008 The outstanding count SHALL be the delay-line occupancy plus the FIFO count, 0..4.
REQ-009 req_ready SHALL be 1 iff the outstanding count is below 4 and flush=0.
REQ-010 Back-pressure: this rule guarantees the FIFO never overflows; a response SHALL remain stable on rsp_data/rsp_addr/rsp_err while rsp_valid=1 and rsp_ready=0.
REQ-011 A FIFO pop SHALL occur when rsp_valid=1 and rsp_ready=1.
REQ-012 Push and pop in the same cycle SHALL leave the FIFO count unchanged, including when the FIFO is full.
REQ-013 The FIFO read/write pointers SHALL wrap modulo 4.
REQ-014 Error condition: req_addr[1:0] != 0 or req_addr[31:2] >= DEPTH.
REQ-015 On an error, the response SHALL carry rsp_err=1 and rsp_data=32'h00000013 (NOP), and SHALL NOT read memory.
REQ-016 When rsp_valid=0, rsp_data, rsp_addr and rsp_err SHALL all be 0.
REQ-017 flush=1 SHALL invalidate all delay-line stages and empty the FIFO at that edge.
REQ-018 Flush ordering: a request presented in a flush cycle is dropped, rsp_valid is 0 in the following cycle, and req_ready is 1 again the cycle after flush deasserts.
REQ-019 When wr_en=1 and wr_addr is aligned and in range, mem[wr_addr[31:2]] SHALL be written with wr_data at the edge.
REQ-020 A misaligned or out-of-range write SHALL be ignored.
REQ-021 Same-cycle read and write of one word SHALL return the old data (read-before-write).

Reset
REQ-022 During reset=1, all delay-line valids SHALL clear, FIFO pointers and count SHALL be 0, and req_ready, rsp_valid, rsp_data, rsp_addr and rsp_err SHALL be 0.
REQ-023 Memory contents SHALL NOT be affected by reset.
REQ-024 Reset asserted mid-operation SHALL discard all outstanding fetches without emitting any response.
REQ-025 req_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-026 A shared package imem_pkg SHALL hold: RSP_FIFO_DEPTH=4, NOP_INSTR=32'h00000013, the LATENCY legal bounds, and a response record type {data[31:0], addr[31:0], err}.
REQ-027 The 4-entry response FIFO SHALL be a sub-module named resp_fifo, with push/pop, full/empty and count outputs; the memory array and delay line SHALL stay in imem_responder.

Verification
REQ-028 Load 0x00500093 at byte 0x0 and 0x00A00113 at 0x4; fetch 0x0 then 0x4 back-to-back with rsp_ready=1 -> responses appear in cycles 2 and 3 (LATENCY=2), in order, with err=0.
REQ-029 Hold rsp_ready=0 and issue 6 requests -> exactly 4 are accepted and req_ready=0 thereafter; release rsp_ready -> 4 ordered responses, data stable while stalled.
REQ-030 Fetch 0x2 and 0x400 (DEPTH=256) -> both responses carry rsp_err=1 and rsp_data=0x00000013, with rsp_addr echoed.
REQ-031 With 3 fetches outstanding, assert flush for 1 cycle together with a new request -> no response for any of the four, and req_ready=1 one cycle later.
REQ-032 Write 0xDEADBEEF to 0x8 and fetch 0x8 in the same cycle -> old word returned; refetch -> 0xDEADBEEF.
REQ-033 Assert reset for 1 cycle mid-stream -> all outputs 0, no stale response, and previously loaded memory still readable.
